// File: rtl/relu_maxpool_2x2.sv
// relu_maxpool_2x2
//
// Post-processing stage behind the 2D Sobel convolution engine. It takes the
// engine's raster-ordered stream of signed results and applies ReLU. It then
// applies 2x2 max-pooling with stride 2 and emits the pooled map in raster
// order. A frame is armed by start_signal, and frame completion is reported
// with a one-cycle done_signal pulse.
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-low reset
//   start_signal one-cycle pulse, arms the block for a new frame (IDLE only)
//   data_in      signed convolution result, DATA_W bits
//   data_valid   data_in valid this cycle (no backpressure)
//   pool_out     signed pooled value (always >= 0), holds when not valid
//   pool_valid   one-cycle strobe per pooled sample
//   done_signal  one-cycle pulse, the cycle after the final pool_valid
//   busy         high from frame arming until done_signal pulses
module relu_maxpool_2x2 #(
    parameter int IN_W   = 30,
    parameter int IN_H   = 30,
    parameter int DATA_W = 22
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_signal,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     data_valid,
    output logic signed [DATA_W-1:0] pool_out,
    output logic                     pool_valid,
    output logic                     done_signal,
    output logic                     busy
);

    localparam int XW   = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int YW   = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int CI   = (XW > 1) ? XW - 1 : 1;
    localparam int RB   = IN_W / 2;
    localparam int NOUT = (IN_W / 2) * (IN_H / 2);
    localparam int CW   = $clog2(NOUT + 1);

    localparam logic [XW-1:0] X_LAST = XW'(IN_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IN_H - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Negative results carry no feature energy downstream; clamp to zero.
    function automatic logic signed [DATA_W-1:0] relu(
        input logic signed [DATA_W-1:0] v
    );
        return v[DATA_W-1] ? '0 : v;
    endfunction

    // Signed maximum; operands are post-ReLU so no width growth is possible.
    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    state_t                    r_state;
    logic [XW-1:0]             r_in_x;
    logic [YW-1:0]             r_in_y;
    logic [CW-1:0]             r_out_cnt;
    logic signed [DATA_W-1:0]  r_hold;
    logic signed [DATA_W-1:0]  r_row_buf [RB];
    logic signed [DATA_W-1:0]  r_pool_p1;
    logic                      r_vld_p1;
    logic                      r_done;
    logic                      r_busy;

    logic                      w_accept_p0;
    logic                      w_x_last_p0;
    logic                      w_y_last_p0;
    logic [CI-1:0]             w_col_p0;
    logic signed [DATA_W-1:0]  w_relu_p0;
    logic signed [DATA_W-1:0]  w_hmax_p0;
    logic signed [DATA_W-1:0]  w_vmax_p0;

    // ---- stage p0: accept, ReLU, horizontal and vertical max ----
    assign w_accept_p0 = (r_state == S_RUN) && data_valid;
    assign w_x_last_p0 = (r_in_x == X_LAST);
    assign w_y_last_p0 = (r_in_y == Y_LAST);
    assign w_col_p0    = CI'(r_in_x >> 1);
    assign w_relu_p0   = relu(data_in);
    assign w_hmax_p0   = smax(r_hold, w_relu_p0);
    assign w_vmax_p0   = smax(r_row_buf[w_col_p0], w_hmax_p0);

    // ---- stage p1: registered pooled result, control FSM ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_in_x    <= '0;
            r_in_y    <= '0;
            r_out_cnt <= '0;
            r_hold    <= '0;
            for (int i = 0; i < RB; i++) begin
                r_row_buf[i] <= '0;
            end
            r_pool_p1 <= '0;
            r_vld_p1  <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_vld_p1 <= 1'b0;
            r_done   <= 1'b0;

            if (r_vld_p1) begin
                r_out_cnt <= r_out_cnt + C_ONE;
            end

            case (r_state)
                S_IDLE: begin
                    if (start_signal) begin
                        r_state   <= S_RUN;
                        r_in_x    <= '0;
                        r_in_y    <= '0;
                        r_out_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end

                S_RUN: begin
                    if (w_accept_p0) begin
                        // Even columns open a horizontal pair; odd columns close it.
                        if (!r_in_x[0]) begin
                            r_hold <= w_relu_p0;
                        end else if (!r_in_y[0]) begin
                            // Top row of a window: park the pair max for the next row.
                            r_row_buf[w_col_p0] <= w_hmax_p0;
                        end else begin
                            r_pool_p1 <= w_vmax_p0;
                            r_vld_p1  <= 1'b1;
                        end

                        if (w_x_last_p0) begin
                            r_in_x <= '0;
                            if (w_y_last_p0) begin
                                r_in_y  <= '0;
                                r_state <= S_DONE;
                            end else begin
                                r_in_y <= r_in_y + Y_ONE;
                            end
                        end else begin
                            r_in_x <= r_in_x + X_ONE;
                        end
                    end
                end

                S_DONE: begin
                    // The final pool_valid is visible during this cycle.
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pool_out    = r_pool_p1;
    assign pool_valid  = r_vld_p1;
    assign done_signal = r_done;
    assign busy        = r_busy;

endmodule
